conv_frame_sched: RTL and testbench

Frame scheduler for the conv1 feature-map datapath. On a start pulse it raster-scans one IMG_W x IMG_H input image out of the image memory and drives the valid strobe of the 5x5 convolution datapath. It tracks which datapath results correspond to fully populated K x K windows and forwards only those, each tagged with its output feature-map address. It reports busy, done and a sticky alignment error.

---
 rtl/conv_frame_sched_if.sv | 33 +++
 rtl/conv_frame_sched.sv | 164 ++++++++++++++++
 tb/tb_conv_frame_sched.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_sched_if.sv
// Signal bundle between the conv1 frame scheduler, the image memory, the convolution
// datapath and the result sink. The master side is the scheduler.
interface conv_frame_sched_if #(
  parameter int DATA_WIDTH     = 24,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_ADDR_WIDTH = 10
);
  logic                          start;
  logic                          hold;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic                          mem_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          conv_valid_in;
  logic                          conv_valid_out;
  logic signed [DATA_WIDTH-1:0]  conv_data_out;
  logic                          out_valid;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic [OUT_ADDR_WIDTH-1:0]     out_addr;

  modport master (
    input  start, hold, conv_valid_out, conv_data_out,
    output busy, done, err, mem_en, mem_addr, conv_valid_in,
           out_valid, out_data, out_addr
  );

  modport slave (
    output start, hold, conv_valid_out, conv_data_out,
    input  busy, done, err, mem_en, mem_addr, conv_valid_in,
           out_valid, out_data, out_addr
  );
endinterface

// File: rtl/conv_frame_sched.sv
// Frame scheduler for the conv1 datapath: raster-scans the image memory, strobes the datapath
// and forwards only results belonging to fully populated KxK windows, tagged with their index.
module conv_frame_sched #(
  parameter int DATA_WIDTH     = 24,
  parameter int IMG_W          = 28,
  parameter int IMG_H          = 28,
  parameter int K              = 5,
  parameter int CONV_LAT       = 3,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  conv_frame_sched_if.master bus
);
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PIPE_D  = CONV_LAT + 2;
  localparam int DRAIN_W = $clog2(CONV_LAT + 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [ROW_W-1:0]             r_row;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             w_row;
  logic [COL_W-1:0]             w_col;
  logic [ROW_W-1:0]             w_row_nxt;
  logic [COL_W-1:0]             w_col_nxt;
  logic [DRAIN_W-1:0]           r_drain;
  logic                         w_start_acc;
  logic                         w_issue;
  logic                         w_last_pix;
  logic                         w_win;
  logic                         w_accept;
  logic                         w_misalign;
  logic [ADDR_WIDTH-1:0]        w_pix_addr;

  // Index 0 is aligned with mem_en, index 1 with conv_valid_in, the top with conv_valid_out.
  logic [PIPE_D-1:0]            r_iss_pipe;
  logic [PIPE_D-1:0]            r_win_pipe;

  logic [ADDR_WIDTH-1:0]        r_mem_addr;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_err;
  logic [OUT_ADDR_WIDTH-1:0]    r_out_cnt;
  logic                         r_out_valid;
  logic [OUT_ADDR_WIDTH-1:0]    r_out_addr;
  logic signed [DATA_WIDTH-1:0] r_out_data;

  // The accepting start cycle issues pixel (0,0) itself so mem_en follows start by one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_issue     = 1'b0;
    w_row       = r_row;
    w_col       = r_col;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_RUN;
          w_row       = '0;
          w_col       = '0;
          w_issue     = !bus.hold;
        end
      end
      S_RUN:   w_issue = !bus.hold;
      S_DRAIN: begin
        if (r_drain == DRAIN_W'(CONV_LAT + 2)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_last_pix = (w_row == ROW_W'(IMG_H - 1)) && (w_col == COL_W'(IMG_W - 1));
    if (w_issue && w_last_pix) w_state_nxt = S_DRAIN;

    if (w_col == COL_W'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = w_row + ROW_W'(1);
    end else begin
      w_col_nxt = w_col + COL_W'(1);
      w_row_nxt = w_row;
    end

    w_win      = (w_row >= ROW_W'(K - 1)) && (w_col >= COL_W'(K - 1));
    w_pix_addr = ADDR_WIDTH'(int'(w_row) * IMG_W + int'(w_col));
  end

  assign w_accept   = bus.conv_valid_out && r_win_pipe[PIPE_D-1];
  assign w_misalign = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                      (bus.conv_valid_out != r_iss_pipe[PIPE_D-1]);

  // ---- p0: control, scan counters and issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_drain    <= '0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_issue) begin
        r_row      <= w_row_nxt;
        r_col      <= w_col_nxt;
        r_mem_addr <= w_pix_addr;
      end else if (w_start_acc) begin
        r_row <= '0;
        r_col <= '0;
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + DRAIN_W'(1) : '0;
      if (w_start_acc)     r_err <= 1'b0;
      else if (w_misalign) r_err <= 1'b1;
    end
  end

  // ---- p1..p(CONV_LAT+1): issue/window flags riding alongside the datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_pipe <= '0;
      r_win_pipe <= '0;
    end else begin
      r_iss_pipe <= {r_iss_pipe[PIPE_D-2:0], w_issue};
      r_win_pipe <= {r_win_pipe[PIPE_D-2:0], w_issue & w_win};
    end
  end

  // ---- p(CONV_LAT+2): forward gated results with their feature-map index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data <= bus.conv_data_out;
        r_out_addr <= r_out_cnt;
      end
      if (w_start_acc)   r_out_cnt <= '0;
      else if (w_accept) r_out_cnt <= r_out_cnt + OUT_ADDR_WIDTH'(1);
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.mem_en        = r_iss_pipe[0];
  assign bus.mem_addr      = r_mem_addr;
  assign bus.conv_valid_in = r_iss_pipe[1];
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_addr      = r_out_addr;
endmodule

// File: tb/tb_conv_frame_sched.sv
// Bench for conv_frame_sched: memory + datapath model driving random image data, with a
// queue-based reference of the expected windowed outputs.
module tb_conv_frame_sched;
  localparam int DW   = 24;
  localparam int IW   = 28;
  localparam int IH   = 28;
  localparam int KK   = 5;
  localparam int LAT  = 3;
  localparam int AW   = 10;
  localparam int OAW  = 10;
  localparam int NPIX = IW * IH;
  localparam int NOUT = (IW - KK + 1) * (IH - KK + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_frame_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_ADDR_WIDTH(OAW)) bus ();

  conv_frame_sched #(
    .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .CONV_LAT(LAT),
    .ADDR_WIDTH(AW), .OUT_ADDR_WIDTH(OAW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] img [NPIX];
  logic          dp_v [LAT+1];
  logic [AW-1:0] dp_a [LAT+1];
  logic [DW-1:0] garbage;
  logic          inject_early;

  // Memory (1 cycle) plus datapath (LAT cycles), tracking which pixel each slot carries.
  always @(posedge clk) begin
    dp_v[0] <= bus.mem_en;
    dp_a[0] <= bus.mem_addr;
    for (int i = 1; i <= LAT; i++) begin
      dp_v[i] <= dp_v[i-1];
      dp_a[i] <= dp_a[i-1];
    end
    garbage <= DW'($urandom);
  end

  // Fault mode: the result for pixel 0 comes back one cycle early.
  always_comb begin
    logic late_ok;
    logic early;
    late_ok = dp_v[LAT] && !(inject_early && dp_a[LAT] == '0);
    early   = inject_early && dp_v[LAT-1] && (dp_a[LAT-1] == '0);
    bus.conv_valid_out = late_ok || early;
    if (late_ok)    bus.conv_data_out = img[dp_a[LAT]];
    else if (early) bus.conv_data_out = img[0];
    else            bus.conv_data_out = garbage;
  end

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.hold = 1'b0; inject_early = 1'b0;
    for (int i = 0; i < NPIX; i++) img[i] = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_en, bus.conv_valid_in, bus.out_valid} !== 6'b0)
      begin n_errors++; $display("FAIL reset_ctrl: got %b required 000000",
        {bus.busy, bus.done, bus.err, bus.mem_en, bus.conv_valid_in, bus.out_valid}); end
    n_checks++;
    if (bus.mem_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0)
      begin n_errors++; $display("FAIL reset_data: got addr=%0d oaddr=%0d data=%0h required 0",
        bus.mem_addr, bus.out_addr, bus.out_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0)
      begin n_errors++; $display("FAIL idle_after_reset: got busy=%b mem_en=%b required 0 0",
        bus.busy, bus.mem_en); end
  endtask

  // One full frame from an IDLE start; optional spurious starts in RUN, DRAIN and DONE.
  task automatic run_frame(input int hold_pct, input bit spurious, input bit exp_err,
                           input string tag);
    logic [DW-1:0] exp_q[$];
    int issued, outs, gaps, cyc, done_cyc, last_out_cyc, done_cnt;
    bit prev_cvo, prev_busy, prev_me;
    logic [DW-1:0] prev_cdo;
    logic [AW-1:0] prev_pa;

    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    for (int r = KK - 1; r < IH; r++)
      for (int c = KK - 1; c < IW; c++) exp_q.push_back(img[r*IW + c]);

    bus.hold = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    issued = 0; outs = 0; gaps = 0; cyc = 0; done_cyc = -1; last_out_cyc = -1; done_cnt = 0;
    prev_cvo = 1'b0; prev_busy = 1'b0; prev_me = 1'b0; prev_cdo = '0; prev_pa = '0;

    n_checks++;
    if (bus.mem_en !== 1'b1 || bus.busy !== 1'b1 || bus.err !== 1'b0)
      begin n_errors++; $display("FAIL %s start_latency: got mem_en=%b busy=%b err=%b required 1 1 0",
        tag, bus.mem_en, bus.busy, bus.err); end

    while (done_cyc < 0 && cyc < 4 * NPIX) begin
      n_checks++;
      if (bus.conv_valid_in !== prev_me)
        begin n_errors++; $display("FAIL %s valid_in_delay: got %b required %b cycle %0d",
          tag, bus.conv_valid_in, prev_me, cyc); end
      if (bus.mem_en) begin
        n_checks++;
        if (bus.mem_addr !== AW'(issued))
          begin n_errors++; $display("FAIL %s addr_seq: got %0d required %0d", tag, bus.mem_addr, issued); end
        issued++;
      end else if (hold_pct == 0 && issued > 0 && issued < NPIX) gaps++;
      if (bus.out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL %s extra_output: got out_addr=%0d required none", tag, bus.out_addr);
        end else begin
          if (bus.out_data !== exp_q[0] || bus.out_addr !== OAW'(outs))
            begin n_errors++; $display("FAIL %s out_seq: got data=%0h addr=%0d required data=%0h addr=%0d",
              tag, bus.out_data, bus.out_addr, exp_q[0], outs); end
          void'(exp_q.pop_front());
        end
        n_checks++;
        if (!prev_cvo || bus.out_data !== prev_cdo)
          begin n_errors++; $display("FAIL %s passthru: got %0h required %0h (prev valid %b)",
            tag, bus.out_data, prev_cdo, prev_cvo); end
        n_checks++;
        if (int'(prev_pa) / IW < KK - 1 || int'(prev_pa) % IW < KK - 1)
          begin n_errors++; $display("FAIL %s window_gate: got pixel %0d required row,col >= %0d",
            tag, prev_pa, KK - 1); end
        if (outs == 0) begin
          n_checks++;
          if (prev_pa !== AW'((KK - 1) * IW + KK - 1))
            begin n_errors++; $display("FAIL %s first_window: got pixel %0d required %0d",
              tag, prev_pa, (KK - 1) * IW + KK - 1); end
        end
        outs++;
        last_out_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++; done_cyc = cyc;
        n_checks++;
        if (bus.busy !== 1'b0 || prev_busy !== 1'b1)
          begin n_errors++; $display("FAIL %s busy_fall: got busy=%b prev=%b required 0 1",
            tag, bus.busy, prev_busy); end
        n_checks++;
        if (bus.err !== exp_err)
          begin n_errors++; $display("FAIL %s err_at_done: got %b required %b", tag, bus.err, exp_err); end
      end
      prev_cvo = bus.conv_valid_out; prev_cdo = bus.conv_data_out;
      prev_pa = dp_a[LAT]; prev_busy = bus.busy; prev_me = bus.mem_en;
      bus.hold  = ($urandom_range(99) < hold_pct);
      bus.start = spurious && (cyc == 50 || (issued == NPIX && bus.busy) || bus.done);
      @(negedge clk);
      cyc++;
    end
    bus.hold = 1'b0;

    n_checks++;
    if (done_cyc < 0) begin n_errors++; $display("FAIL %s done_timeout: got none in %0d cycles required 1", tag, cyc); end
    n_checks++;
    if (issued != NPIX) begin n_errors++; $display("FAIL %s pixel_count: got %0d required %0d", tag, issued, NPIX); end
    n_checks++;
    if (outs != NOUT) begin n_errors++; $display("FAIL %s out_count: got %0d required %0d", tag, outs, NOUT); end
    n_checks++;
    if (done_cyc != last_out_cyc + 1)
      begin n_errors++; $display("FAIL %s done_timing: got cycle %0d required %0d", tag, done_cyc, last_out_cyc + 1); end
    if (hold_pct == 0) begin
      n_checks++;
      if (gaps != 0) begin n_errors++; $display("FAIL %s issue_gaps: got %0d required 0", tag, gaps); end
    end

    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.mem_en, bus.out_valid, bus.done, bus.busy} !== 4'b0 || bus.err !== exp_err ||
          bus.out_addr !== OAW'(NOUT - 1))
        begin n_errors++; $display("FAIL %s post_idle: got en=%b ov=%b done=%b busy=%b err=%b oaddr=%0d required 0 0 0 0 %b %0d",
          tag, bus.mem_en, bus.out_valid, bus.done, bus.busy, bus.err, bus.out_addr, exp_err, NOUT - 1); end
      bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe;
    int cyc;
    bus.hold = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.mem_en && bus.mem_addr == AW'(300)) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (cyc >= 2000) begin n_errors++; $display("FAIL rst_mid reach_300: got timeout required mem_addr 300"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_en, bus.conv_valid_in, bus.out_valid} !== 6'b0 ||
        bus.mem_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0)
      begin n_errors++; $display("FAIL rst_mid outputs_zero: got ctrl=%b addr=%0d oaddr=%0d data=%0h required 0",
        {bus.busy, bus.done, bus.err, bus.mem_en, bus.conv_valid_in, bus.out_valid},
        bus.mem_addr, bus.out_addr, bus.out_data); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.done, bus.mem_en, bus.busy, bus.err} !== 5'b0)
        begin n_errors++; $display("FAIL rst_mid quiet: got ov=%b done=%b en=%b busy=%b err=%b required 0",
          bus.out_valid, bus.done, bus.mem_en, bus.busy, bus.err); end
    end
  endtask

  initial begin
    test_reset;
    run_frame(0, 1'b0, 1'b0, "basic");
    run_frame(30, 1'b0, 1'b0, "hold30");
    run_frame(0, 1'b1, 1'b0, "start_ignore");
    run_frame(0, 1'b0, 1'b0, "restart");
    test_reset_midframe;
    run_frame(0, 1'b0, 1'b0, "after_rst");
    inject_early = 1'b1;
    run_frame(0, 1'b0, 1'b1, "early_err");
    inject_early = 1'b0;
    run_frame(20, 1'b0, 1'b0, "err_clear");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
